imem_loader: RTL and testbench

- Write-side initiator for the 256-byte, word-organised instruction memory; fills it before the fetch path reads it.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit instruction words.
- Writes each word at word-aligned, incrementing byte addresses, then signals completion.
- Sits between the boot/debug byte source and the instruction memory's write port.

---
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs bytes little-endian into
// 32-bit words and writes them at incrementing word-aligned addresses.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              wrap_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  written_reg;
  logic [CNT_W-1:0]  written_inc;
  logic [1:0]        lane_reg;
  logic [31:0]       word_reg;
  logic [31:0]       packed_word;
  logic              accept;
  logic              last_word;

  assign byte_ready  = (state_reg == COLLECT);
  assign accept      = byte_ready && byte_valid;
  assign written_inc = written_reg + 1'b1;
  assign last_word   = (written_inc == count_reg);

  // Current word with the incoming byte merged into its lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign packed_word[gi*8 +: 8] = (lane_reg == 2'(gi)) ? byte_in : word_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (word_count == '0) ? DONE : COLLECT;
      COLLECT: begin
        if (abort)                         state_next = IDLE;
        else if (accept && lane_reg == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        if (abort)          state_next = IDLE;
        else if (last_word) state_next = DONE;
        else                state_next = COLLECT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wrap_err    <= 1'b0;
      addr_reg    <= '0;
      count_reg   <= '0;
      written_reg <= '0;
      lane_reg    <= '0;
      word_reg    <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg    <= {base_addr[ADDR_W-1:2], 2'b00};
            count_reg   <= word_count;
            written_reg <= '0;
            lane_reg    <= '0;
            wrap_err    <= 1'b0;
            busy        <= 1'b1;
            if (word_count == '0) done <= 1'b1;
          end
        end
        COLLECT: begin
          if (abort) begin
            busy     <= 1'b0;
            lane_reg <= '0;
          end else if (accept) begin
            word_reg <= packed_word;
            lane_reg <= lane_reg + 2'd1;
            // Issue the write strobe on the same edge that takes the 4th byte.
            if (lane_reg == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr_reg;
              mem_wdata <= packed_word;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            busy <= 1'b0;
          end else begin
            addr_reg    <= addr_reg + ADDR_STEP;
            written_reg <= written_inc;
            if (addr_reg == LAST_ADDR && !last_word) wrap_err <= 1'b1;
            if (last_word) done <= 1'b1;
          end
        end
        DONE:    busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write log taken on falling edges, expected
// addresses and words are hand-computed constants.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [6:0]  word_count;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        wrap_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int bad_ready = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.ADDR_W(8), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .wrap_err(wrap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      $display("write addr=%02h data=%08h", mem_addr, mem_wdata);
      if (byte_ready) bad_ready++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic do_start(input logic [7:0] b, input logic [6:0] n);
    base_addr = b; word_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in = b; byte_valid = 1'b1; t = 0;
    while (!byte_ready && t < 50) begin @(negedge clk); t++; end
    if (!byte_ready) check("ready_timeout", {31'b0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 300) begin @(negedge clk); t++; end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  initial begin
    int n0;
    int d0;
    logic [31:0] w2 [3];
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    abort = 1'b0; byte_in = '0; byte_valid = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_we", {31'b0, mem_we}, 0);
    check("rst_ready", {31'b0, byte_ready}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single word at 0x00
    n0 = wr_addr.size();
    do_start(8'h00, 7'd1);
    check("t1_busy", {31'b0, busy}, 1);
    send_word(32'h00000013, 0);
    check("t1_we", {31'b0, mem_we}, 1);
    check("t1_addr", {24'b0, mem_addr}, 32'h00);
    check("t1_data", mem_wdata, 32'h00000013);
    check("t1_ready_in_write", {31'b0, byte_ready}, 0);
    @(negedge clk);
    check("t1_we_one_cycle", {31'b0, mem_we}, 0);
    check("t1_done", {31'b0, done}, 1);
    @(negedge clk);
    check("t1_done_pulse", {31'b0, done}, 0);
    check("t1_busy_low", {31'b0, busy}, 0);
    check("t1_nwrites", wr_addr.size() - n0, 1);

    // Three words at 0x13 -> 0x10 with random gaps
    w2[0] = 32'h00500093; w2[1] = 32'h00100113; w2[2] = 32'h002081B3;
    n0 = wr_addr.size();
    do_start(8'h13, 7'd3);
    for (int i = 0; i < 3; i++) send_word(w2[i], 3);
    wait_done();
    @(negedge clk);
    check("t2_nwrites", wr_addr.size() - n0, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_addr%0d", i), {24'b0, wr_addr[n0+i]}, 32'h10 + 32'(4*i));
      check($sformatf("t2_data%0d", i), wr_data[n0+i], w2[i]);
    end
    check("t2_ready_in_write", bad_ready, 0);

    // Wrap from 0xFC to 0x00
    n0 = wr_addr.size();
    do_start(8'hF8, 7'd3);
    send_word(32'h11111111, 1);
    send_word(32'h22222222, 1);
    send_word(32'h33333333, 1);
    wait_done();
    @(negedge clk);
    check("t3_nwrites", wr_addr.size() - n0, 3);
    check("t3_addr0", {24'b0, wr_addr[n0]}, 32'hF8);
    check("t3_addr1", {24'b0, wr_addr[n0+1]}, 32'hFC);
    check("t3_addr2", {24'b0, wr_addr[n0+2]}, 32'h00);
    check("t3_data2", wr_data[n0+2], 32'h33333333);
    repeat (5) @(negedge clk);
    check("t3_wrap_held", {31'b0, wrap_err}, 1);

    // Abort during word 2
    n0 = wr_addr.size(); d0 = done_cnt;
    do_start(8'h20, 7'd3);
    check("t4_wrap_cleared", {31'b0, wrap_err}, 0);
    send_word(32'hAABBCCDD, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_busy_low", {31'b0, busy}, 0);
    repeat (6) @(negedge clk);
    check("t4_nwrites", wr_addr.size() - n0, 1);
    check("t4_addr", {24'b0, wr_addr[n0]}, 32'h20);
    check("t4_no_done", done_cnt - d0, 0);
    n0 = wr_addr.size();
    do_start(8'h40, 7'd1);
    send_word(32'hCAFEF00D, 2);
    wait_done();
    @(negedge clk);
    check("t4_reload_addr", {24'b0, wr_addr[n0]}, 32'h40);
    check("t4_reload_data", wr_data[n0], 32'hCAFEF00D);

    // Asynchronous reset mid-collect
    n0 = wr_addr.size();
    do_start(8'h80, 7'd2);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", {31'b0, busy}, 0);
    check("t5_ready", {31'b0, byte_ready}, 0);
    check("t5_addr", {24'b0, mem_addr}, 0);
    check("t5_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b1; byte_in = 8'h77;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    check("t5_no_write", wr_addr.size() - n0, 0);
    do_start(8'h60, 7'd1);
    send_byte(8'h01, 0);
    do_start(8'hA0, 7'd5);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    wait_done();
    @(negedge clk);
    check("t5_nwrites", wr_addr.size() - n0, 1);
    check("t5_addr_kept", {24'b0, wr_addr[n0]}, 32'h60);
    check("t5_data", wr_data[n0], 32'h04030201);

    // Zero-length load
    n0 = wr_addr.size();
    do_start(8'h10, 7'd0);
    check("t6_done", {31'b0, done}, 1);
    check("t6_ready", {31'b0, byte_ready}, 0);
    @(negedge clk);
    check("t6_done_pulse", {31'b0, done}, 0);
    check("t6_busy_low", {31'b0, busy}, 0);
    check("t6_no_write", wr_addr.size() - n0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
